// File: rtl/qsfp_mgmt.sv
// QSFP cage sequencer: debounce insertion, pulse ResetL, wait init, then select and flag ready.
// Outputs are registered from next state; optional sticky interrupt flag built with QSFP_INTL_LATCH_EN.
module qsfp_mgmt #(
  parameter int DEBOUNCE_CYC = 1024,
  parameter int RESET_CYC    = 1250,
  parameter int INIT_CYC     = 250000000,
  parameter int CNT_W        = 28
) (
  input  logic       sysclk,
  input  logic       resetl,
  input  logic       qsfp_modprsl,
  input  logic       qsfp_intl,
  input  logic       enable,
  input  logic       reinit,
  input  logic       lpmode_req,
  input  logic       intl_clr,
  output logic       qsfp_resetl,
  output logic       qsfp_lpmode,
  output logic       qsfp_modsel,
  output logic       module_ready,
  output logic [2:0] state,
  output logic [7:0] insert_count,
  output logic       intl_latched
);

  typedef enum logic [2:0] {
    ST_ABSENT   = 3'd0,
    ST_DEBOUNCE = 3'd1,
    ST_RESET    = 3'd2,
    ST_INIT     = 3'd3,
    ST_READY    = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RESET_CYC - 1);
  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYC - 1);

  state_t           cur_st, nxt_st;
  logic [CNT_W-1:0] timer;
  logic             timer_inc;
  logic             cnt_inc;
  logic [1:0]       prs_sync;
  logic             present;

  always_ff @(posedge sysclk or negedge resetl) begin
    if (!resetl) prs_sync <= 2'b11;
    else         prs_sync <= {prs_sync[0], qsfp_modprsl};
  end

  assign present = ~prs_sync[1];

  always_comb begin
    nxt_st    = cur_st;
    timer_inc = 1'b0;
    cnt_inc   = 1'b0;
    case (cur_st)
      ST_ABSENT: begin
        if (enable && present) nxt_st = ST_DEBOUNCE;
      end
      ST_DEBOUNCE: begin
        if (!enable || !present)  nxt_st = ST_ABSENT;
        else if (timer == DEB_LAST) nxt_st = ST_RESET;
        else                        timer_inc = 1'b1;
      end
      ST_RESET: begin
        if (!enable || !present) nxt_st = ST_ABSENT;
        else if (timer == RST_LAST) begin
          nxt_st  = ST_INIT;
          cnt_inc = 1'b1;
        end else timer_inc = 1'b1;
      end
      ST_INIT: begin
        if (!enable || !present)     nxt_st = ST_ABSENT;
        else if (timer == INIT_LAST) nxt_st = ST_READY;
        else                         timer_inc = 1'b1;
      end
      ST_READY: begin
        if (!enable || !present) nxt_st = ST_ABSENT;
        else if (reinit)         nxt_st = ST_RESET;
      end
      default: nxt_st = ST_ABSENT;
    endcase
  end

  // Timer only runs in the bounded states, so it cannot wrap while parked in READY.
  always_ff @(posedge sysclk or negedge resetl) begin
    if (!resetl) begin
      cur_st       <= ST_ABSENT;
      timer        <= '0;
      insert_count <= 8'd0;
      qsfp_resetl  <= 1'b0;
      qsfp_lpmode  <= 1'b1;
      qsfp_modsel  <= 1'b1;
      module_ready <= 1'b0;
    end else begin
      cur_st <= nxt_st;
      if (nxt_st != cur_st) timer <= '0;
      else if (timer_inc)   timer <= timer + 1'b1;
      if (cnt_inc && insert_count != 8'hFF) insert_count <= insert_count + 8'd1;
      qsfp_resetl  <= (nxt_st == ST_INIT) || (nxt_st == ST_READY);
      qsfp_lpmode  <= ((nxt_st == ST_INIT) || (nxt_st == ST_READY)) ? lpmode_req : 1'b1;
      qsfp_modsel  <= (nxt_st != ST_READY);
      module_ready <= (nxt_st == ST_READY);
    end
  end

  assign state = cur_st;

`ifdef QSFP_INTL_LATCH_EN
  logic [1:0] intl_sync;

  always_ff @(posedge sysclk or negedge resetl) begin
    if (!resetl) intl_sync <= 2'b11;
    else         intl_sync <= {intl_sync[0], qsfp_intl};
  end

  // Set beats clear; losing the module wipes any stale interrupt.
  always_ff @(posedge sysclk or negedge resetl) begin
    if (!resetl)                                          intl_latched <= 1'b0;
    else if (nxt_st == ST_ABSENT && cur_st != ST_ABSENT)  intl_latched <= 1'b0;
    else if (cur_st == ST_READY && !intl_sync[1])         intl_latched <= 1'b1;
    else if (intl_clr)                                    intl_latched <= 1'b0;
  end
`else
  logic unused_intl;
  assign unused_intl  = qsfp_intl ^ intl_clr;
  assign intl_latched = 1'b0;
`endif

endmodule
